// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle accumulator CPU controller.
// Holds the state encoding, opcode constants and datapath select encodings.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_WB_ALU  = 4'd4,
        S_MEM_RD  = 4'd5,
        S_LOAD_WB = 4'd6,
        S_MEM_WR  = 4'd7,
        S_JUMP    = 4'd8,
        S_BRANCH  = 4'd9,
        S_FAULT   = 4'd10
    } state_t;

    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_STORE  = 4'b0001;
    localparam logic [3:0] OP_JUMP   = 4'b0010;
    localparam logic [3:0] OP_BRANCH = 4'b0100;
    localparam logic [3:0] OP_RTYPE  = 4'b1000;
    localparam logic [1:0] OP_ITYPE  = 2'b11;

    localparam logic [1:0] PC_SRC_ALU = 2'b00;
    localparam logic [1:0] PC_SRC_IMM = 2'b01;
    localparam logic [1:0] PC_SRC_REL = 2'b10;

    localparam logic [1:0] ALUB_REG = 2'b00;
    localparam logic [1:0] ALUB_ONE = 2'b01;
    localparam logic [1:0] ALUB_IMM = 2'b10;

    localparam logic ALUA_PC  = 1'b0;
    localparam logic ALUA_ACC = 1'b1;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_force_add;
        logic       fault;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory handshake between the controller (master) and the memory system (slave).
interface multicycle_controller_if;

    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  i_or_d,
        output mem_ready
    );

endinterface

// File: rtl/multicycle_controller_timer.sv
// Memory wait-cycle counter: cleared on entry to a memory state, counts cycles
// with mem_ready low, flags when the count reaches MEM_TIMEOUT (0 = never).
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_wait,
    output logic o_limit_hit
);

    localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_wait) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            assign o_limit_hit = 1'b0;
        end else begin : g_on
            assign o_limit_hit = i_wait && (r_count == CW'(MEM_TIMEOUT));
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the 16-bit multicycle accumulator CPU: steps each
// instruction through fetch/decode/execute/memory/writeback and drives the datapath.
module multicycle_controller
    import mcu_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              op,
    input  logic                    is_move_to,
    input  logic                    is_nop,
    input  logic                    zero,
    multicycle_controller_if.master mem,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic [1:0]              pc_src,
    output logic                    reg_write,
    output logic                    reg_dst,
    output logic                    mem_to_reg,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic                    alu_force_add,
    output logic                    fault,
    output logic [CNT_W-1:0]        retired_count,
    output logic [3:0]              state
);

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    ctrl_t            w_ctrl;
    ctrl_t            w_out;
    logic             w_wait;
    logic             w_clr;
    logic             w_limit_hit;
    logic [CNT_W-1:0] r_retired;

    assign w_wait = is_mem_state(r_state) && !mem.mem_ready;
    assign w_clr  = is_mem_state(w_next) && (w_next != r_state);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_clr),
        .i_wait      (w_wait),
        .o_limit_hit (w_limit_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        w_ctrl   = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_req       = 1'b1;
                w_ctrl.i_or_d        = 1'b0;
                w_ctrl.alu_src_a     = ALUA_PC;
                w_ctrl.alu_src_b     = ALUB_ONE;
                w_ctrl.alu_force_add = 1'b1;
                w_ctrl.pc_src        = PC_SRC_ALU;
                if (mem.mem_ready) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_next          = S_DECODE;
                end else if (w_limit_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                if (op == OP_LOAD) begin
                    w_next = S_MEM_RD;
                end else if (op == OP_STORE) begin
                    w_next = S_MEM_WR;
                end else if (op == OP_JUMP) begin
                    w_next = S_JUMP;
                end else if (op == OP_BRANCH) begin
                    w_next = S_BRANCH;
                end else if (op == OP_RTYPE) begin
                    if (is_nop) begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        w_next = S_EXEC_R;
                    end
                end else if (op[3:2] == OP_ITYPE) begin
                    w_next = S_EXEC_I;
                end else begin
                    w_next = S_FAULT;
                end
            end
            S_EXEC_R: begin
                w_ctrl.alu_src_a = ALUA_ACC;
                w_ctrl.alu_src_b = ALUB_REG;
                w_next           = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_ctrl.alu_src_a = ALUA_ACC;
                w_ctrl.alu_src_b = ALUB_IMM;
                w_next           = S_WB_ALU;
            end
            S_WB_ALU: begin
                // One writeback state serves both exec paths; IR is stable, so
                // re-deriving the B select from op holds the exec-state ALU inputs.
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b0;
                w_ctrl.reg_dst    = is_move_to;
                w_ctrl.alu_src_a  = ALUA_ACC;
                w_ctrl.alu_src_b  = (op[3:2] == OP_ITYPE) ? ALUB_IMM : ALUB_REG;
                w_next            = S_FETCH;
                w_retire          = 1'b1;
            end
            S_MEM_RD: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.i_or_d  = 1'b1;
                if (mem.mem_ready) begin
                    w_next = S_LOAD_WB;
                end else if (w_limit_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_LOAD_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_dst    = 1'b0;
                w_next            = S_FETCH;
                w_retire          = 1'b1;
            end
            S_MEM_WR: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.i_or_d  = 1'b1;
                w_ctrl.mem_we  = 1'b1;
                if (mem.mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_limit_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_JUMP: begin
                w_ctrl.pc_write = 1'b1;
                w_ctrl.pc_src   = PC_SRC_IMM;
                w_next          = S_FETCH;
                w_retire        = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = ALUA_ACC;
                w_ctrl.alu_src_b = ALUB_REG;
                w_ctrl.pc_src    = PC_SRC_REL;
                w_ctrl.pc_write  = zero;
                w_next           = S_FETCH;
                w_retire         = 1'b1;
            end
            S_FAULT: begin
                w_ctrl.fault = 1'b1;
            end
            default: begin
                w_next = S_FAULT;
            end
        endcase
    end

    assign w_out = rst_n ? w_ctrl : '0;

    assign mem.mem_req    = w_out.mem_req;
    assign mem.mem_we     = w_out.mem_we;
    assign mem.i_or_d     = w_out.i_or_d;
    assign ir_write       = w_out.ir_write;
    assign pc_write       = w_out.pc_write;
    assign pc_src         = w_out.pc_src;
    assign reg_write      = w_out.reg_write;
    assign reg_dst        = w_out.reg_dst;
    assign mem_to_reg     = w_out.mem_to_reg;
    assign alu_src_a      = w_out.alu_src_a;
    assign alu_src_b      = w_out.alu_src_b;
    assign alu_force_add  = w_out.alu_force_add;
    assign fault          = w_out.fault;
    assign retired_count  = r_retired;
    assign state          = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: two instances (default and
// short-timeout/narrow-counter) driven together against a phase-sequence model.
module tb_multicycle_controller;
    import mcu_pkg::*;

    typedef enum int {
        P_FETCH, P_DEC, P_EXR, P_EXI, P_WBR, P_WBI,
        P_MRD, P_LWB, P_MWR, P_JMP, P_BR, P_FLT
    } phase_e;

    typedef struct {
        phase_e p;
        logic   rdy;
    } ph_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] op;
    logic       is_move_to;
    logic       is_nop;
    logic       zero;
    logic       ready;

    int n_tests = 0;
    int n_fail  = 0;
    int rc      = 0;

    always #5 clk = ~clk;

    multicycle_controller_if bus_a ();
    multicycle_controller_if bus_b ();
    assign bus_a.mem_ready = ready;
    assign bus_b.mem_ready = ready;

    logic        a_ir_write, a_pc_write, a_reg_write, a_reg_dst, a_mem_to_reg;
    logic        a_alu_src_a, a_alu_force_add, a_fault;
    logic [1:0]  a_pc_src, a_alu_src_b;
    logic [15:0] a_rc;
    logic [3:0]  a_state;
    logic        b_ir_write, b_pc_write, b_reg_write, b_reg_dst, b_mem_to_reg;
    logic        b_alu_src_a, b_alu_force_add, b_fault;
    logic [1:0]  b_pc_src, b_alu_src_b;
    logic [1:0]  b_rc;
    logic [3:0]  b_state;

    multicycle_controller #(.CNT_W(16), .MEM_TIMEOUT(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .op(op), .is_move_to(is_move_to), .is_nop(is_nop),
        .zero(zero), .mem(bus_a), .ir_write(a_ir_write), .pc_write(a_pc_write),
        .pc_src(a_pc_src), .reg_write(a_reg_write), .reg_dst(a_reg_dst),
        .mem_to_reg(a_mem_to_reg), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .alu_force_add(a_alu_force_add), .fault(a_fault), .retired_count(a_rc),
        .state(a_state)
    );

    multicycle_controller #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .op(op), .is_move_to(is_move_to), .is_nop(is_nop),
        .zero(zero), .mem(bus_b), .ir_write(b_ir_write), .pc_write(b_pc_write),
        .pc_src(b_pc_src), .reg_write(b_reg_write), .reg_dst(b_reg_dst),
        .mem_to_reg(b_mem_to_reg), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .alu_force_add(b_alu_force_add), .fault(b_fault), .retired_count(b_rc),
        .state(b_state)
    );

    // {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write, reg_dst,
    //  mem_to_reg, alu_src_a, alu_src_b, alu_force_add, fault}
    logic [14:0] w_a, w_b;
    assign w_a = {bus_a.mem_req, bus_a.mem_we, bus_a.i_or_d, a_ir_write, a_pc_write,
                  a_pc_src, a_reg_write, a_reg_dst, a_mem_to_reg, a_alu_src_a,
                  a_alu_src_b, a_alu_force_add, a_fault};
    assign w_b = {bus_b.mem_req, bus_b.mem_we, bus_b.i_or_d, b_ir_write, b_pc_write,
                  b_pc_src, b_reg_write, b_reg_dst, b_mem_to_reg, b_alu_src_a,
                  b_alu_src_b, b_alu_force_add, b_fault};

    function automatic logic [14:0] exp_word(input phase_e p, input logic rdy,
                                             input logic z, input logic mv);
        logic mreq, mwe, iod, irw, pcw, rw, rd, m2r, asa, fadd, flt;
        logic [1:0] pcs, asb;
        {mreq, mwe, iod, irw, pcw, rw, rd, m2r, asa, fadd, flt} = '0;
        pcs = 2'b00;
        asb = 2'b00;
        case (p)
            P_FETCH: begin mreq = 1; asb = 2'b01; fadd = 1; irw = rdy; pcw = rdy; end
            P_EXR:   begin asa = 1; end
            P_EXI:   begin asa = 1; asb = 2'b10; end
            P_WBR:   begin rw = 1; rd = mv; asa = 1; end
            P_WBI:   begin rw = 1; rd = mv; asa = 1; asb = 2'b10; end
            P_MRD:   begin mreq = 1; iod = 1; end
            P_LWB:   begin rw = 1; m2r = 1; end
            P_MWR:   begin mreq = 1; iod = 1; mwe = 1; end
            P_JMP:   begin pcw = 1; pcs = 2'b01; end
            P_BR:    begin asa = 1; pcs = 2'b10; pcw = z; end
            P_FLT:   begin flt = 1; end
            default: ;
        endcase
        return {mreq, mwe, iod, irw, pcw, pcs, rw, rd, m2r, asa, asb, fadd, flt};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enter at posedge+1; leaves at the following posedge+1.
    task automatic step(input phase_e p, input logic rdy, input bit chk_b);
        logic [14:0] e;
        ready = rdy;
        @(negedge clk);
        e = exp_word(p, rdy, zero, is_move_to);
        chk({p.name(), "_a"}, 32'(w_a), 32'(e));
        if (chk_b) chk({p.name(), "_b"}, 32'(w_b), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned ncyc);
        rst_n = 1'b0;
        ready = 1'b1;
        for (int unsigned i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk("reset_outputs_a", 32'(w_a), 32'd0);
            chk("reset_outputs_b", 32'(w_b), 32'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        rc = 0;
    endtask

    task automatic run_instr(input logic [3:0] op_v, input logic mv, input logic nop,
                             input logic z, input int unsigned fw, input int unsigned mw,
                             input bit chk_b);
        ph_t q[$];
        bit  legal;
        legal      = 1'b1;
        op         = op_v;
        is_move_to = mv;
        is_nop     = nop;
        zero       = z;
        chk("start_state_a", 32'(a_state), 32'(S_FETCH));
        chk("start_retired_a", 32'(a_rc), 32'(rc % 65536));
        if (chk_b) begin
            chk("start_state_b", 32'(b_state), 32'(S_FETCH));
            chk("start_retired_b", 32'(b_rc), 32'(rc % 4));
        end
        for (int unsigned i = 0; i < fw; i++) q.push_back('{P_FETCH, 1'b0});
        q.push_back('{P_FETCH, 1'b1});
        q.push_back('{P_DEC, rbit()});
        if (op_v == 4'b0000) begin
            for (int unsigned i = 0; i < mw; i++) q.push_back('{P_MRD, 1'b0});
            q.push_back('{P_MRD, 1'b1});
            q.push_back('{P_LWB, rbit()});
        end else if (op_v == 4'b0001) begin
            for (int unsigned i = 0; i < mw; i++) q.push_back('{P_MWR, 1'b0});
            q.push_back('{P_MWR, 1'b1});
        end else if (op_v == 4'b0010) begin
            q.push_back('{P_JMP, rbit()});
        end else if (op_v == 4'b0100) begin
            q.push_back('{P_BR, rbit()});
        end else if (op_v == 4'b1000) begin
            if (!nop) begin
                q.push_back('{P_EXR, rbit()});
                q.push_back('{P_WBR, rbit()});
            end
        end else if (op_v >= 4'b1100) begin
            q.push_back('{P_EXI, rbit()});
            q.push_back('{P_WBI, rbit()});
        end else begin
            legal = 1'b0;
            for (int i = 0; i < 3; i++) q.push_back('{P_FLT, rbit()});
        end
        foreach (q[i]) step(q[i].p, q[i].rdy, chk_b);
        if (legal) rc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] legal_ops [8];
        logic [3:0] bad_ops [7];
        legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1100, 4'b1101, 4'b1111};
        bad_ops   = '{4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010, 4'b1011};
        rst_n = 1'b0; op = '0; is_move_to = 1'b0; is_nop = 1'b0; zero = 1'b0; ready = 1'b1;

        do_reset(3);

        // Addi, Load, Store with zero-wait memory
        run_instr(4'b1100, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        run_instr(4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        run_instr(4'b0001, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        chk("retired_after_three", 32'(a_rc), 32'd3);

        // MoveTo, NOP, BranchZ taken and not taken, Jump
        run_instr(4'b1000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        run_instr(4'b1000, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
        run_instr(4'b0100, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        run_instr(4'b0100, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        run_instr(4'b0010, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

        // Randomized legal instruction stream with short memory waits
        for (int n = 0; n < 40; n++) begin
            run_instr(legal_ops[$urandom_range(7, 0)], rbit(), rbit(), rbit(),
                      $urandom_range(3, 0), $urandom_range(3, 0), 1'b1);
        end

        // Fetch stalled 5 cycles completes on the 6th for the long-timeout instance
        run_instr(4'b1100, 1'b0, 1'b0, 1'b0, 5, 0, 1'b0);
        do_reset(2);

        // Short-timeout instance faults after 5 wait cycles
        for (int i = 0; i < 5; i++) step(P_FETCH, 1'b0, 1'b1);
        ready = 1'b0;
        @(negedge clk);
        chk("timeout_fault_word_b", 32'(w_b), 32'(exp_word(P_FLT, 1'b0, zero, is_move_to)));
        chk("timeout_state_b", 32'(b_state), 32'(S_FAULT));
        chk("timeout_still_wait_a", 32'(w_a), 32'(exp_word(P_FETCH, 1'b0, zero, is_move_to)));
        @(posedge clk);
        #1;
        do_reset(1);

        // Illegal opcode faults without retiring; reset recovers
        run_instr(4'b1101, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        run_instr(4'b0111, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        chk("illegal_retired_a", 32'(a_rc), 32'(rc));
        chk("illegal_state_a", 32'(a_state), 32'(S_FAULT));
        do_reset(1);
        run_instr(bad_ops[$urandom_range(6, 0)], rbit(), rbit(), rbit(),
                  $urandom_range(3, 0), 0, 1'b1);
        chk("bad_retired_a", 32'(a_rc), 32'(rc));
        do_reset(1);

        // Narrow counter wraps: 5 NOPs leave 1
        for (int i = 0; i < 5; i++) run_instr(4'b1000, rbit(), 1'b1, rbit(), 0, 0, 1'b1);
        chk("cnt_wrap_b", 32'(b_rc), 32'(rc % 4));
        chk("cnt_wide_a", 32'(a_rc), 32'(rc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
